// File: rtl/qnigma_pkg.sv
// Shared qnigma definitions: FIFO tag layout helpers and the tag struct carried ahead of each
// packed word.
package qnigma_pkg;

    // Widest nbytes_m1 field any packer configuration can need (RATIO up to 256).
    localparam int unsigned NBYTES_W_MAX = 8;

    typedef struct packed {
        logic                    last;
        logic [NBYTES_W_MAX-1:0] nbytes_m1;
    } qnigma_tag_t;

    function automatic int unsigned nbytes_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int unsigned tag_w(input int unsigned ratio);
        return 1 + nbytes_w(ratio);
    endfunction

endpackage

// File: rtl/qnigma_fifo_wr_packer.sv
// Packs IN_WIDTH symbols little-endian into DATA_WIDTH words tagged {last, nbytes-1} for a
// dual-clock FIFO write port. Define QNIGMA_PACKER_TIMEOUT_EN to flush idle partial words.
module qnigma_fifo_wr_packer
    import qnigma_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  IN_WIDTH   = 8,
    parameter int unsigned  TIMEOUT    = 16,
    localparam int unsigned RATIO      = DATA_WIDTH / IN_WIDTH,
    localparam int unsigned NB_W       = nbytes_w(RATIO),
    localparam int unsigned TAG_W      = tag_w(RATIO)
) (
    input  logic                        clk_w,
    input  logic                        rst_w,
    input  logic                        in_valid,
    input  logic [IN_WIDTH-1:0]         in_data,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic                        fifo_write,
    output logic [TAG_W+DATA_WIDTH-1:0] fifo_data,
    input  logic                        fifo_full,
    output logic [15:0]                 pkt_cnt
);

    if (DATA_WIDTH % IN_WIDTH != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("qnigma_fifo_wr_packer: invalid DATA_WIDTH/IN_WIDTH/TIMEOUT");
    end

    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_ins;
    logic [NB_W-1:0]       cnt_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_word_q;
    qnigma_tag_t           out_tag_q;
    logic [15:0]           pkt_cnt_q;
    logic                  accept;
    logic                  complete;
    logic                  flush;

    // The FIFO does not guard its write pointer, so writes are gated by fifo_full here.
    assign fifo_write = out_valid_q && !fifo_full;
    // Output register is free when empty or being drained this cycle.
    assign in_ready   = !out_valid_q || !fifo_full;
    assign accept     = in_valid && in_ready;
    assign complete   = accept && (in_last || cnt_q == NB_W'(RATIO - 1));
    assign fifo_data  = {out_tag_q.last, NB_W'(out_tag_q.nbytes_m1), out_word_q};
    assign pkt_cnt    = pkt_cnt_q;

    always_comb begin
        acc_ins = acc_q;
        acc_ins[cnt_q*IN_WIDTH +: IN_WIDTH] = in_data;
    end

`ifdef QNIGMA_PACKER_TIMEOUT_EN
    logic [7:0] idle_q;

    // Saturates at TIMEOUT-1 so a flush blocked by a stalled output fires once it drains.
    assign flush = !accept && cnt_q != '0 && idle_q == 8'(TIMEOUT - 1) && in_ready;

    always_ff @(posedge clk_w or posedge rst_w) begin
        if (rst_w) begin
            idle_q <= '0;
        end else if (accept || flush || cnt_q == '0) begin
            idle_q <= '0;
        end else if (idle_q != 8'(TIMEOUT - 1)) begin
            idle_q <= idle_q + 8'd1;
        end
    end
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk_w or posedge rst_w) begin
        if (rst_w) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_tag_q   <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            if (complete) begin
                out_word_q  <= acc_ins;
                out_tag_q   <= '{last: in_last, nbytes_m1: NBYTES_W_MAX'(cnt_q)};
                out_valid_q <= 1'b1;
                cnt_q       <= '0;
                acc_q       <= '0;
            end else if (flush) begin
                out_word_q  <= acc_q;
                out_tag_q   <= '{last: 1'b0, nbytes_m1: NBYTES_W_MAX'(cnt_q - 1'b1)};
                out_valid_q <= 1'b1;
                cnt_q       <= '0;
                acc_q       <= '0;
            end else begin
                if (accept) begin
                    acc_q <= acc_ins;
                    cnt_q <= cnt_q + 1'b1;
                end
                if (fifo_write) begin
                    out_valid_q <= 1'b0;
                end
            end
            if (fifo_write && out_tag_q.last) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_qnigma_fifo_wr_packer.sv
// Self-checking bench for qnigma_fifo_wr_packer: directed scenarios plus a randomized run
// scored against a byte-queue packing model.
module tb_qnigma_fifo_wr_packer;

    localparam int unsigned DW      = 32;
    localparam int unsigned IW      = 8;
    localparam int unsigned RATIO   = DW / IW;
    localparam int unsigned TW      = 3 + DW;
    localparam int unsigned TIMEOUT = 16;

    logic          clk_w = 1'b0;
    logic          rst_w = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          fifo_write;
    logic [TW-1:0] fifo_data;
    logic          fifo_full = 1'b0;
    logic [15:0]   pkt_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int model_pkts = 0;
    logic [IW-1:0] cur_q[$];
    logic [TW-1:0] exp_q[$];
    int            write_cycles[$];

    qnigma_fifo_wr_packer #(
        .DATA_WIDTH(DW),
        .IN_WIDTH  (IW),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_w     (clk_w),
        .rst_w     (rst_w),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .fifo_write(fifo_write),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk_w = ~clk_w;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference packing: bytes collect in a queue; a word closes at RATIO bytes or on last.
    task automatic model_close(input logic last);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < cur_q.size(); i++) begin
            w = w | (DW'(cur_q[i]) << (IW * i));
        end
        exp_q.push_back({last, 2'(cur_q.size() - 1), w});
        if (last) model_pkts++;
        cur_q.delete();
    endtask

    task automatic model_accept(input logic [IW-1:0] d, input logic l);
        cur_q.push_back(d);
        if (cur_q.size() == RATIO || l) model_close(l);
    endtask

    // One clock: drive at the falling edge, observe 1ns later, then score writes/acceptance.
    task automatic cycle(input logic v, input logic [IW-1:0] d, input logic l, input logic full);
        @(negedge clk_w);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        fifo_full = full;
        #1;
        cyc++;
        if (fifo_full) chk("no_write_when_full", fifo_write, 0);
        if (fifo_write) begin
            write_cycles.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_write", fifo_write, 0);
            else chk("write_data", fifo_data, exp_q.pop_front());
        end
        if (in_valid && in_ready) model_accept(d, l);
    endtask

    task automatic do_reset();
        @(negedge clk_w);
        rst_w     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        fifo_full = 1'b0;
        #1;
        chk("rst_fifo_write", fifo_write, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_fifo_data", fifo_data, 0);
        cur_q.delete();
        exp_q.delete();
        model_pkts = 0;
        @(negedge clk_w);
        rst_w = 1'b0;
    endtask

    initial begin
        logic [15:0] p0;
        int          streak;
        logic        v;
        logic        f;
        logic        l;

        do_reset();

        // Two full words, no last; second word appears the cycle after byte 8.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 5) begin
                chk("w1_latency", fifo_write, 1);
                chk("w1_data", fifo_data, {1'b0, 2'd3, 32'h0403_0201});
            end
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("w2_write", fifo_write, 1);
        chk("w2_data", fifo_data, {1'b0, 2'd3, 32'h0807_0605});
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("w2_single", fifo_write, 0);

        // Short packet.
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        cycle(1'b1, 8'hCC, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("short_write", fifo_write, 1);
        chk("short_data", fifo_data, {1'b1, 2'd2, 32'h00CC_BBAA});
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("short_pkt_cnt", pkt_cnt, 1);

        // Back-pressure with a pending word.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'h99, 1'b0, 1'b1);
            chk("stall_write", fifo_write, 0);
            chk("stall_ready", in_ready, 0);
            chk("stall_data", fifo_data, {1'b0, 2'd3, 32'h1312_1110});
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("release_write", fifo_write, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("release_single", fifo_write, 0);

        // 64-byte streaming packet: one write every RATIO cycles.
        p0 = pkt_cnt;
        write_cycles.delete();
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i * 3 + 1), i == 63, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stream_writes", write_cycles.size(), 16);
        for (int k = 1; k < write_cycles.size(); k++) begin
            chk("stream_gap", write_cycles[k] - write_cycles[k-1], RATIO);
        end
        chk("stream_pkt_cnt", pkt_cnt, 16'(p0 + 16'd1));

        // Partial word left idle.
        do_reset();
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int n = 1; n <= TIMEOUT + 4; n++) begin
`ifdef QNIGMA_PACKER_TIMEOUT_EN
            if (n == TIMEOUT + 1) model_close(1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk("timeout_write", fifo_write, n == TIMEOUT + 1);
            if (n == TIMEOUT + 1) chk("timeout_data", fifo_data, {1'b0, 2'd1, 32'h0000_A55A});
`else
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk("hold_no_write", fifo_write, 0);
`endif
        end

        // Reset mid-word discards the partial lanes.
        do_reset();
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        cycle(1'b1, 8'hDD, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk("post_rst_no_write", fifo_write, 0);
        end
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clean_write", fifo_write, 1);
        chk("clean_data", fifo_data, {1'b0, 2'd3, 32'h4433_2211});

        // Randomized traffic with back-pressure; idle streaks kept well under TIMEOUT.
        do_reset();
        streak = 0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom % 4) != 0;
            f = ($urandom % 4) == 0;
            l = ($urandom % 12) == 0;
            if (streak >= 8) begin
                v = 1'b1;
                f = 1'b0;
            end
            cycle(v, 8'($urandom), l, f);
            if (in_valid && in_ready) streak = 0;
            else streak++;
        end
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rand_scoreboard_empty", exp_q.size(), 0);
        chk("rand_pkt_cnt", pkt_cnt, 16'(model_pkts));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qnigma_fifo_wr_packer.md
QNIGMA_FIFO_WR_PACKER -- requirements
Module: qnigma_fifo_wr_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: packed word width in bits; SHALL be a multiple of IN_WIDTH.
REQ-002 Parameter IN_WIDTH, default 8: input symbol (byte) width.
REQ-003 Parameter TIMEOUT, default 16: idle cycles before a partial-word flush (used only under QNIGMA_PACKER_TIMEOUT_EN); range 1..255.
REQ-004 Reset rst_w, asynchronous, active-high; clock clk_w. Ports: clk_w input 1 clock; rst_w input 1 reset.
REQ-005 in_valid input 1: input byte valid.
REQ-006 in_data input IN_WIDTH: input byte.
REQ-007 in_last input 1: current byte ends the packet.
REQ-008 in_ready output 1: byte accepted on clk_w edge when in_valid && in_ready.
REQ-009 fifo_write output 1: write strobe to dual-clock FIFO write port.
REQ-010 fifo_data output TAG_W+DATA_WIDTH: {last, nbytes-1, word}; TAG_W = 1 + clog2(RATIO), RATIO = DATA_WIDTH/IN_WIDTH.
REQ-011 fifo_full input 1: registered FIFO full flag, write-clock domain.
REQ-012 pkt_cnt output 16: count of packets (last-tagged words) written to FIFO, wraps at 2^16.

Function
REQ-013 Packing SHALL be little-endian: k-th accepted byte of a word lands at bits [k*IN_WIDTH +: IN_WIDTH]; unfilled lanes SHALL be zero.
REQ-014 Internal state: accumulator + lane count cnt (0..RATIO-1); output register with out_valid flag.
REQ-015 Word completes on acceptance of byte with cnt==RATIO-1 or in_last=1; on that edge accumulator+tag SHALL move to output register, out_valid=1, cnt=0, accumulator cleared.
REQ-016 Tag: nbytes = lanes filled (1..RATIO), encoded as nbytes-1; last = in_last of completing byte.
REQ-017 fifo_write SHALL equal out_valid && !fifo_full (combinational); fifo_data driven from output register only.
REQ-018 fifo_write SHALL never assert while fifo_full=1 (FIFO does not guard its write address).
REQ-019 in_ready SHALL equal !out_valid || !fifo_full; back-to-back full words SHALL sustain one FIFO write per RATIO cycles with no bubbles.
REQ-020 Same-edge drain and refill: out_valid stays 1, output register loads new word.
REQ-021 Latency: completing byte accepted at edge k -> fifo_write high in cycle after edge k if fifo_full=0.
REQ-022 pkt_cnt SHALL increment on each edge where fifo_write=1 and tag last=1.
REQ-023 Stall: while out_valid && fifo_full, in_ready=0, all state held, fifo_data stable.

Reset
REQ-024 On rst_w: cnt=0, accumulator=0, out_valid=0, output register=0, pkt_cnt=0, timeout counter=0; thus fifo_write=0, in_ready=1.
REQ-025 Reset mid-packet SHALL discard partial and pending words; no FIFO write in or after the reset cycle until new input.

Configuration
REQ-026 Macro QNIGMA_PACKER_TIMEOUT_EN defined: idle counter counts cycles with cnt>0 and no byte accepted; reaching TIMEOUT SHALL flush partial word to output register with last=0, nbytes=cnt (only when output register free or draining); counter clears on any acceptance.
REQ-027 Macro undefined: no idle counter; partial words held indefinitely until word completion or in_last.

Structure
REQ-028 Shared package qnigma_pkg SHALL hold the tag field widths/positions helper constants and a typedef for the tag struct {last, nbytes_m1}.
REQ-029 No sub-module; single flat module intended to instantiate directly ahead of qnigma dual-clock FIFO write port.

Verification
REQ-030 Reset, 8 bytes 01..08 no last, fifo_full=0 -> two writes, data 0x04030201 then 0x08070605, tag last=0 nbytes_m1=3.
REQ-031 3 bytes AA,BB,CC with last on CC -> one write data 0x00CCBBAA, last=1, nbytes_m1=2; pkt_cnt=1.
REQ-032 fifo_full=1 held 10 cycles with pending word -> fifo_write=0, in_ready=0, fifo_data stable; release -> single write next cycle.
REQ-033 Continuous 64-byte packet with last on byte 64 -> 16 writes, no gaps after first, only last word tagged last=1.
REQ-034 With QNIGMA_PACKER_TIMEOUT_EN, TIMEOUT=16: 2 bytes then idle -> write after 16 idle cycles, nbytes_m1=1, last=0; without macro -> no write.
REQ-035 rst_w pulse after 2 bytes of a word -> no write; next 4 bytes produce one clean word without stale lanes.
